mc_sequencer: RTL and testbench
===============================

Name: mc_sequencer

Overview:
- Multi-cycle control FSM for the MIPS datapath. It sequences fetch, decode, execute, memory and writeback over several clocks, with a ready handshake to a shared instruction/data memory.
- Decodes the same subset the single-cycle control decoder handles: J, JAL, R-type ADD/SUB/AND/OR/SLT/JR/SYSCALL/nop, BEQ, BNE, ADDI, ADDIU, ORI, LW, SW, LUI.
- Drives datapath mux selects, write enables and a 3-bit ALU op every cycle.

Parameters:
WAIT_W, 8, width of memory-wait counter; timeout fires when counter reaches 2^WAIT_W-1 with mem_ready still low.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous reset, active-high
instr  input  32  current IR contents; op=[31:26], funct=[5:0]
mem_ready  input  1  memory has completed the current read/write this cycle
zero  input  1  ALU zero flag
syscall_done  input  1  host has finished servicing syscall
mem_read  output  1  memory read request
mem_write  output  1  memory write request
iord  output  1  0=PC address, 1=ALUOut address
ir_write  output  1  load IR from memory data
pc_write  output  1  update PC
pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
alu_src_a  output  1  0=PC, 1=rs
alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_op  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 011 LUI
reg_write  output  1  register file write enable
reg_dst  output  2  00 rt, 01 rd, 10 $31
mem_to_reg  output  2  00 ALUOut, 01 MDR, 10 PC
syscall  output  1  syscall request, held until syscall_done
illegal  output  1  sticky: unsupported opcode/funct decoded
mem_error  output  1  sticky: memory wait timeout

Behaviour:
- Reset: while rst=1, every output is 0, state becomes FETCH, wait counter is 0 and sticky flags are cleared. A reset mid-instruction abandons the instruction and drops any memory request on the next edge.
- Output structure: all outputs decode from state. pc_write and ir_write are additionally gated by mem_ready in FETCH and by zero in BRANCH.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00.
  - mem_ready=1: ir_write=1 and pc_write=1 in that same cycle; next state DECODE.
  - mem_ready=0: stay in FETCH and increment the wait counter.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Next state by op/funct:
  - R-ALU -> EXEC_R.
  - ADDI/ADDIU/ORI/LUI -> EXEC_I.
  - LW/SW -> MEM_ADDR.
  - BEQ/BNE -> BRANCH.
  - J/JAL -> JUMP.
  - JR -> JR.
  - SYSCALL -> SYSCALL.
  - funct 000000 (nop) -> FETCH.
  - anything else -> ILLEGAL.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct -> WB_R.
- WB_R: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op is ADD for ADDI/ADDIU, OR for ORI, 011 for LUI -> WB_I.
- WB_I: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read=1, iord=1; stays until mem_ready -> WB_MEM.
- WB_MEM: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- MEM_WR: mem_write=1, iord=1; stays until mem_ready -> FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01.
  - pc_write=zero for BEQ, pc_write=~zero for BNE.
  - Next state FETCH.
- JUMP: pc_write=1, pc_source=10. For JAL also reg_write=1, reg_dst=10, mem_to_reg=10; the PC already holds PC+4. Next state FETCH.
- JR: pc_write=1, pc_source=11, reg_write=0 -> FETCH.
- SYSCALL: syscall=1 until syscall_done=1 -> FETCH. No timeout applies here.
- Wait counter:
  - Counts only in FETCH, MEM_RD and MEM_WR while mem_ready=0.
  - Clears on every state change.
  - Reaching all-ones with mem_ready=0 -> ERROR.
  - mem_ready=1 in the same cycle as all-ones wins (normal completion).
- ILLEGAL/ERROR:
  - Terminal states; only rst exits.
  - Sticky flags: illegal=1 in ILLEGAL, mem_error=1 in ERROR.
  - All other outputs are 0 in both states.
- syscall_done or mem_ready asserted outside the waiting state is ignored.

Optional Feature:
MC_SEQ_PERF_EN
- Defined:
  - Adds output ports cycle_count[31:0] and instr_count[31:0].
  - cycle_count increments every non-reset cycle.
  - instr_count increments on every transition into FETCH from a non-FETCH state.
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: the ports are absent and the counter logic is not compiled.

Test Plan:
- ADD (op 000000, funct 100000) with mem_ready=1 in the first FETCH cycle -> FETCH, DECODE, EXEC_R, WB_R; reg_write=1, reg_dst=01 in cycle 4; back in FETCH in cycle 5.
- LW with mem_ready low for 3 cycles in MEM_RD -> mem_read=1, iord=1 held 4 cycles; then WB_MEM with mem_to_reg=01, reg_dst=00.
- BEQ with zero=0 -> pc_write=0 in BRANCH. BNE with zero=0 -> pc_write=1, pc_source=01.
- JAL -> pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10 in one cycle. JR -> pc_source=11, reg_write=0.
- WAIT_W=4, mem_ready held 0 in FETCH -> mem_error=1 after 15 waiting cycles and stays set. Then pulse rst -> mem_error=0 and FETCH resumes. Op 111111 -> illegal=1.
- SYSCALL with syscall_done after 5 cycles -> syscall=1 for exactly 5 cycles, then FETCH. rst asserted during MEM_WR -> mem_write=0 on the next cycle and state is FETCH.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for a MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and
// writeback. Memory accesses wait on mem_ready, and a wait counter guards
// against a memory that never answers. ILLEGAL and ERROR are terminal
// states that only rst leaves. All control outputs are combinational
// decodes of the current state and are forced to 0 while rst is high.
// Optional build macro MC_SEQ_PERF_EN adds cycle and instruction counters.
module mc_sequencer #(
    parameter int WAIT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        syscall_done,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_source,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        syscall,
    output logic        illegal,
    output logic        mem_error
`ifdef MC_SEQ_PERF_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_SYSCALL  = 4'd13,
        S_ILLEGAL  = 4'd14,
        S_ERROR    = 4'd15
    } state_t;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] FN_NOP     = 6'b000000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_SLT     = 6'b101010;

    // ALU operation encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Selects the state that follows DECODE for the instruction in IR.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        state_t nxt;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = S_EXEC_R;
                    FN_JR:      nxt = S_JR;
                    FN_SYSCALL: nxt = S_SYSCALL;
                    FN_NOP:     nxt = S_FETCH;
                    default:    nxt = S_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: nxt = S_EXEC_I;
            OP_LW, OP_SW:   nxt = S_MEM_ADDR;
            OP_BEQ, OP_BNE: nxt = S_BRANCH;
            OP_J, OP_JAL:   nxt = S_JUMP;
            default:        nxt = S_ILLEGAL;
        endcase
        return nxt;
    endfunction

    // ALU operation for a register-register instruction.
    function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
        logic [2:0] aop;
        case (fn)
            FN_SUB:  aop = ALU_SUB;
            FN_AND:  aop = ALU_AND;
            FN_OR:   aop = ALU_OR;
            FN_SLT:  aop = ALU_SLT;
            default: aop = ALU_ADD;
        endcase
        return aop;
    endfunction

    // ALU operation for an immediate-form instruction.
    function automatic logic [2:0] itype_alu_op(input logic [5:0] op);
        logic [2:0] aop;
        case (op)
            OP_ORI:  aop = ALU_OR;
            OP_LUI:  aop = ALU_LUI;
            default: aop = ALU_ADD;
        endcase
        return aop;
    endfunction

    state_t              r_state;
    state_t              w_next;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                w_wait_full;
    logic                w_waiting;
    logic [5:0]          w_op;
    logic [5:0]          w_funct;
    logic                w_unused_ir;

    logic        w_mem_read;
    logic        w_mem_write;
    logic        w_iord;
    logic        w_ir_write;
    logic        w_pc_write;
    logic [1:0]  w_pc_source;
    logic        w_alu_src_a;
    logic [1:0]  w_alu_src_b;
    logic [2:0]  w_alu_op;
    logic        w_reg_write;
    logic [1:0]  w_reg_dst;
    logic [1:0]  w_mem_to_reg;
    logic        w_syscall;
    logic        w_illegal;
    logic        w_mem_error;

    assign w_op        = instr[31:26];
    assign w_funct     = instr[5:0];
    // Register fields and immediates are consumed by the datapath, not here.
    assign w_unused_ir = ^instr[25:6];
    assign w_wait_full = (r_wait_cnt == {WAIT_W{1'b1}});
    assign w_waiting   = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);

    // State register; reset returns to FETCH and abandons any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: counts stalled cycles, cleared by any state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (w_next != r_state) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (w_waiting && !mem_ready) begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // Next-state and control decode from the current state.
    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_source  = 2'b00;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 3'b000;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'b00;
        w_mem_to_reg = 2'b00;
        w_syscall    = 1'b0;
        w_illegal    = 1'b0;
        w_mem_error  = 1'b0;
        case (r_state)
            S_FETCH: begin
                // PC+4 is computed by the ALU while the instruction is read.
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_op    = ALU_ADD;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_wait_full) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                w_alu_src_b = 2'b11;
                w_alu_op    = ALU_ADD;
                w_next      = decode_next(w_op, w_funct);
            end
            S_EXEC_R: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b00;
                w_alu_op    = rtype_alu_op(w_funct);
                w_next      = S_WB_R;
            end
            S_WB_R: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 2'b01;
                w_mem_to_reg = 2'b00;
                w_next       = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = itype_alu_op(w_op);
                w_next      = S_WB_I;
            end
            S_WB_I: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 2'b00;
                w_mem_to_reg = 2'b00;
                w_next       = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = ALU_ADD;
                if (w_op == OP_SW) begin
                    w_next = S_MEM_WR;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end else if (w_wait_full) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_MEM_RD;
                end
            end
            S_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 2'b00;
                w_mem_to_reg = 2'b01;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_wait_full) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_MEM_WR;
                end
            end
            S_BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b00;
                w_alu_op    = ALU_SUB;
                w_pc_source = 2'b01;
                if (w_op == OP_BNE) begin
                    w_pc_write = ~zero;
                end else begin
                    w_pc_write = zero;
                end
                w_next = S_FETCH;
            end
            S_JUMP: begin
                // PC already holds PC+4, which is the JAL link value.
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                if (w_op == OP_JAL) begin
                    w_reg_write  = 1'b1;
                    w_reg_dst    = 2'b10;
                    w_mem_to_reg = 2'b10;
                end else begin
                    w_reg_write  = 1'b0;
                    w_reg_dst    = 2'b00;
                    w_mem_to_reg = 2'b00;
                end
                w_next = S_FETCH;
            end
            S_JR: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b11;
                w_next      = S_FETCH;
            end
            S_SYSCALL: begin
                // The host may take arbitrarily long; no timeout here.
                w_syscall = 1'b1;
                if (syscall_done) begin
                    w_next = S_FETCH;
                end else begin
                    w_next = S_SYSCALL;
                end
            end
            S_ILLEGAL: begin
                w_illegal = 1'b1;
                w_next    = S_ILLEGAL;
            end
            S_ERROR: begin
                w_mem_error = 1'b1;
                w_next      = S_ERROR;
            end
            default: begin
                w_next = S_ERROR;
            end
        endcase
    end

    // Reset forces every control output low in the same cycle.
    assign mem_read   = rst ? 1'b0  : w_mem_read;
    assign mem_write  = rst ? 1'b0  : w_mem_write;
    assign iord       = rst ? 1'b0  : w_iord;
    assign ir_write   = rst ? 1'b0  : w_ir_write;
    assign pc_write   = rst ? 1'b0  : w_pc_write;
    assign pc_source  = rst ? 2'b00 : w_pc_source;
    assign alu_src_a  = rst ? 1'b0  : w_alu_src_a;
    assign alu_src_b  = rst ? 2'b00 : w_alu_src_b;
    assign alu_op     = rst ? 3'b000 : w_alu_op;
    assign reg_write  = rst ? 1'b0  : w_reg_write;
    assign reg_dst    = rst ? 2'b00 : w_reg_dst;
    assign mem_to_reg = rst ? 2'b00 : w_mem_to_reg;
    assign syscall    = rst ? 1'b0  : w_syscall;
    assign illegal    = rst ? 1'b0  : w_illegal;
    assign mem_error  = rst ? 1'b0  : w_mem_error;

`ifdef MC_SEQ_PERF_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instr_count;

    // Performance counters: cycles, and instructions retired (re-entries to FETCH).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_count <= 32'd0;
            r_instr_count <= 32'd0;
        end else begin
            r_cycle_count <= r_cycle_count + 32'd1;
            if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
                r_instr_count <= r_instr_count + 32'd1;
            end else begin
                r_instr_count <= r_instr_count;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed testbench for mc_sequencer (WAIT_W=4). Stimulus pushes the
// hand-computed control word expected for each cycle into a queue; a
// monitor on the falling edge pops and compares against the DUT outputs.
module tb_mc_sequencer;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       syscall;
        logic       illegal;
        logic       mem_error;
    } outs_t;

    typedef struct {
        outs_t e;
        outs_t m;
        string nm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        syscall_done = 1'b0;
    logic        mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0]  pc_source, alu_src_b, reg_dst, mem_to_reg;
    logic        alu_src_a, reg_write, syscall, illegal, mem_error;
    logic [2:0]  alu_op;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    localparam outs_t ALL  = '1;
    localparam outs_t NONE = '0;

    mc_sequencer #(.WAIT_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
        .zero(zero), .syscall_done(syscall_done),
        .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .syscall(syscall), .illegal(illegal), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    function automatic outs_t o(input logic mr, input logic mw, input logic io,
                                input logic irw, input logic pcw, input logic [1:0] pcs,
                                input logic asa, input logic [1:0] asb, input logic [2:0] aop,
                                input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
                                input logic sc, input logic il, input logic me);
        outs_t r;
        r.mem_read = mr; r.mem_write = mw; r.iord = io; r.ir_write = irw;
        r.pc_write = pcw; r.pc_source = pcs; r.alu_src_a = asa; r.alu_src_b = asb;
        r.alu_op = aop; r.reg_write = rw; r.reg_dst = rd; r.mem_to_reg = m2r;
        r.syscall = sc; r.illegal = il; r.mem_error = me;
        return r;
    endfunction

    // Hand-written control words for each step of an instruction.
    function automatic outs_t e_fetch(input logic rdy);
        return o(1'b1,1'b0,1'b0,rdy,rdy,2'b00,1'b0,2'b01,3'b010,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_decode();
        return o(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b11,3'b010,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_exec(input logic [1:0] asb, input logic [2:0] aop);
        return o(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,asb,aop,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_wb(input logic [1:0] rd, input logic [1:0] m2r);
        return o(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b1,rd,m2r,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_mem(input logic mr, input logic mw);
        return o(mr,mw,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_branch(input logic pcw);
        return o(1'b0,1'b0,1'b0,1'b0,pcw,2'b01,1'b1,2'b00,3'b110,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_pcjump(input logic [1:0] pcs, input logic rw,
                                       input logic [1:0] rd, input logic [1:0] m2r);
        return o(1'b0,1'b0,1'b0,1'b0,1'b1,pcs,1'b0,2'b00,3'b000,rw,rd,m2r,1'b0,1'b0,1'b0);
    endfunction
    function automatic outs_t e_flags(input logic sc, input logic il, input logic me);
        return o(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,3'b000,1'b0,2'b00,2'b00,sc,il,me);
    endfunction

    function automatic logic [31:0] r_ins(input logic [5:0] fn);
        return {6'b000000, 5'd9, 5'd10, 5'd8, 5'd0, fn};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op);
        return {op, 5'd9, 5'd8, 16'h0010};
    endfunction

    // Drive one cycle of inputs and queue the expected outputs for it.
    task automatic cyc(input logic r, input logic [31:0] ir, input logic rdy,
                       input logic z, input logic done, input outs_t e,
                       input outs_t m, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; instr = ir; mem_ready = rdy; zero = z; syscall_done = done;
        x.e = e; x.m = m; x.nm = nm;
        exp_q.push_back(x);
    endtask

    // Fetch (memory ready at once) followed by decode.
    task automatic fd(input logic [31:0] ir, input string nm);
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_fetch(1'b1), ALL, {nm, "_fetch"});
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_decode(), ALL, {nm, "_decode"});
    endtask

    // Monitor: compare DUT outputs against the queued expectation.
    always @(negedge clk) begin
        outs_t act;
        exp_t  x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            act = o(mem_read, mem_write, iord, ir_write, pc_write, pc_source,
                    alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg,
                    syscall, illegal, mem_error);
            if (x.m != '0) begin
                checks++;
                if (((act ^ x.e) & x.m) !== '0) begin
                    errors++;
                    $display("FAIL %s: actual=%06h expected=%06h", x.nm, act, x.e);
                end
            end
        end
    end

    // Watchdog against a stimulus process that never completes.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [5:0] r_fn_tab  [4] = '{6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] r_aop_tab [4] = '{3'b110, 3'b000, 3'b001, 3'b111};
    logic [5:0] i_op_tab  [4] = '{6'b001000, 6'b001001, 6'b001101, 6'b001111};
    logic [2:0] i_aop_tab [4] = '{3'b010, 3'b010, 3'b001, 3'b011};

    initial begin
        logic [31:0] ir;
        // Reset: all outputs low.
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, NONE, ALL, "reset0");
        cyc(1'b1, 32'h0, 1'b1, 1'b1, 1'b1, NONE, ALL, "reset1");

        // ADD: fetch, decode, exec, writeback to rd.
        ir = r_ins(6'b100000);
        fd(ir, "add");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_exec(2'b00, 3'b010), ALL, "add_exec");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_wb(2'b01, 2'b00), ALL, "add_wb");

        // Remaining R-type ALU ops.
        for (int k = 0; k < 4; k++) begin
            ir = r_ins(r_fn_tab[k]);
            fd(ir, "rop");
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_exec(2'b00, r_aop_tab[k]), ALL, "rop_exec");
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_wb(2'b01, 2'b00), ALL, "rop_wb");
        end

        // Immediate ops: ADDI, ADDIU, ORI, LUI.
        for (int k = 0; k < 4; k++) begin
            ir = i_ins(i_op_tab[k]);
            fd(ir, "iop");
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_exec(2'b10, i_aop_tab[k]), ALL, "iop_exec");
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_wb(2'b00, 2'b00), ALL, "iop_wb");
        end

        // LW with three stalled read cycles.
        ir = i_ins(6'b100011);
        fd(ir, "lw");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_exec(2'b10, 3'b010), ALL, "lw_addr");
        for (int k = 0; k < 3; k++)
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_mem(1'b1, 1'b0), ALL, "lw_rd_wait");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_mem(1'b1, 1'b0), ALL, "lw_rd_done");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_wb(2'b00, 2'b01), ALL, "lw_wb");

        // Branches for both zero values.
        ir = i_ins(6'b000100);
        fd(ir, "beq0");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_branch(1'b0), ALL, "beq_z0");
        fd(ir, "beq1");
        cyc(1'b0, ir, 1'b0, 1'b1, 1'b0, e_branch(1'b1), ALL, "beq_z1");
        ir = i_ins(6'b000101);
        fd(ir, "bne0");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_branch(1'b1), ALL, "bne_z0");
        fd(ir, "bne1");
        cyc(1'b0, ir, 1'b0, 1'b1, 1'b0, e_branch(1'b0), ALL, "bne_z1");

        // Jumps.
        ir = i_ins(6'b000010);
        fd(ir, "j");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_pcjump(2'b10, 1'b0, 2'b00, 2'b00), ALL, "j_jump");
        ir = i_ins(6'b000011);
        fd(ir, "jal");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_pcjump(2'b10, 1'b1, 2'b10, 2'b10), ALL, "jal_jump");
        ir = r_ins(6'b001000);
        fd(ir, "jr");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_pcjump(2'b11, 1'b0, 2'b00, 2'b00), ALL, "jr_jump");

        // Nop returns straight to FETCH; stray syscall_done/mem_ready in decode ignored.
        ir = r_ins(6'b000000);
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_fetch(1'b1), ALL, "nop_fetch");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b1, e_decode(), ALL, "nop_decode");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), ALL, "nop_back_fetch");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_fetch(1'b1), ALL, "nop_fetch2");

        // SYSCALL held for exactly five cycles.
        ir = r_ins(6'b001100);
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_decode(), ALL, "sys_decode");
        for (int k = 0; k < 4; k++)
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_flags(1'b1, 1'b0, 1'b0), ALL, "sys_hold");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b1, e_flags(1'b1, 1'b0, 1'b0), ALL, "sys_done");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), ALL, "sys_back_fetch");

        // SW aborted by reset while the write is pending.
        ir = i_ins(6'b101011);
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_fetch(1'b1), ALL, "sw_fetch");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_decode(), ALL, "sw_decode");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_exec(2'b10, 3'b010), ALL, "sw_addr");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_mem(1'b0, 1'b1), ALL, "sw_wr_wait");
        cyc(1'b1, ir, 1'b0, 1'b0, 1'b0, NONE, ALL, "sw_reset");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), ALL, "sw_after_reset");

        // Boundary: mem_ready arrives while the counter sits at all-ones.
        cyc(1'b1, ir, 1'b0, 1'b0, 1'b0, NONE, ALL, "bnd_reset");
        ir = r_ins(6'b000000);
        for (int k = 0; k < 15; k++)
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), ALL, "bnd_wait");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_fetch(1'b1), ALL, "bnd_ready_wins");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_decode(), ALL, "bnd_decode");

        // Timeout in FETCH: sticky mem_error, cleared only by reset.
        for (int k = 0; k < 15; k++)
            cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), ALL, "to_wait");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, NONE, NONE, "to_edge");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_flags(1'b0, 1'b0, 1'b1), ALL, "to_error");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b1, e_flags(1'b0, 1'b0, 1'b1), ALL, "to_error_sticky");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_flags(1'b0, 1'b0, 1'b1), ALL, "to_error_sticky2");
        cyc(1'b1, ir, 1'b0, 1'b0, 1'b0, NONE, ALL, "to_reset");

        // Illegal opcode 111111.
        ir = {6'b111111, 26'h0};
        fd(ir, "ill_op");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b0, e_flags(1'b0, 1'b1, 1'b0), ALL, "ill_op");
        cyc(1'b0, ir, 1'b1, 1'b0, 1'b1, e_flags(1'b0, 1'b1, 1'b0), ALL, "ill_op_sticky");
        cyc(1'b1, ir, 1'b0, 1'b0, 1'b0, NONE, ALL, "ill_reset");

        // Illegal R-type funct.
        ir = r_ins(6'b111111);
        fd(ir, "ill_fn");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_flags(1'b0, 1'b1, 1'b0), ALL, "ill_fn");
        cyc(1'b1, ir, 1'b0, 1'b0, 1'b0, NONE, ALL, "ill_fn_reset");
        cyc(1'b0, ir, 1'b0, 1'b0, 1'b0, e_fetch(1'b0), ALL, "final_fetch");

        @(negedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL end_mem_read: actual=%0b expected=1", mem_read);
        end
        checks++;
        if (alu_src_b !== 2'b01) begin
            errors++;
            $display("FAIL end_alu_src_b: actual=%0b expected=01", alu_src_b);
        end
        checks++;
        if (alu_op !== 3'b010) begin
            errors++;
            $display("FAIL end_alu_op: actual=%0b expected=010", alu_op);
        end
        checks++;
        if (ir_write !== 1'b0) begin
            errors++;
            $display("FAIL end_ir_write: actual=%0b expected=0", ir_write);
        end
        checks++;
        if (pc_write !== 1'b0) begin
            errors++;
            $display("FAIL end_pc_write: actual=%0b expected=0", pc_write);
        end
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL end_illegal: actual=%0b expected=0", illegal);
        end
        checks++;
        if (mem_error !== 1'b0) begin
            errors++;
            $display("FAIL end_mem_error: actual=%0b expected=0", mem_error);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
